instr_seq: RTL

INSTR_SEQ -- requirements
Module: instr_seq

---
 rtl/instr_seq_pkg.sv | 34 +++
 rtl/instr_seq.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/instr_seq_pkg.sv
// Shared definitions for the instruction sequencer: opcode and state encodings
// plus the fixed 8-bit instruction field layout.
package instr_seq_pkg;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_CMD  = 3'd1,
        OP_LDJ  = 3'd2,
        OP_JMP  = 3'd3,
        OP_LDC  = 3'd4,
        OP_DJNZ = 3'd5,
        OP_WAIT = 3'd6,
        OP_HALT = 3'd7
    } opcode_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_EXEC      = 3'd2,
        ST_OPND_WAIT = 3'd3,
        ST_OPND      = 3'd4,
        ST_WAIT_EV   = 3'd5,
        ST_WAIT_CMD  = 3'd6,
        ST_HALT      = 3'd7
    } state_t;

    localparam int OP_MSB   = 7;
    localparam int OP_LSB   = 5;
    localparam int IMM_MSB  = 4;
    localparam int IMM_W    = 5;
    localparam int CNT_W    = 5;
    localparam int MAX_EV   = 4;

endpackage

// File: rtl/instr_seq.sv
// Instruction sequencer: fetches 8-bit instructions from an external synchronous
// memory, steering its address with relative inc/jump strobes only.
module instr_seq
    import instr_seq_pkg::*;
#(
    parameter int WIDTH_INSTR = 8,
    parameter int WIDTH_ADDR  = 8,
    parameter int NUM_EV      = 4
) (
    input  logic                   rstn,
    input  logic                   clk,
    input  logic                   start,
    input  logic [WIDTH_INSTR-1:0] instr,
    output logic                   inc,
    output logic                   jump,
    output logic                   we_jump,
    output logic [WIDTH_ADDR-1:0]  data_jump,
    input  logic [NUM_EV-1:0]      ev,
    output logic                   cmd_valid,
    output logic [IMM_W-1:0]       cmd_data,
    input  logic                   cmd_ready,
    output logic                   busy,
    output logic                   halted
);

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic              cmd_valid_reg;
    logic [IMM_W-1:0]  cmd_data_reg;
    logic [1:0]        wait_idx_reg;
    logic              cmd_load;
    logic [MAX_EV-1:0] ev_pad;

    opcode_t          op;
    logic [IMM_W-1:0] imm;

    assign op  = opcode_t'(instr[OP_MSB:OP_LSB]);
    assign imm = instr[IMM_MSB:0];

    // Event indices beyond NUM_EV read as permanently asserted.
    genvar gi;
    generate
        for (gi = 0; gi < MAX_EV; gi++) begin : g_ev_pad
            if (gi < NUM_EV) begin : g_real
                assign ev_pad[gi] = ev[gi];
            end else begin : g_tied
                assign ev_pad[gi] = 1'b1;
            end
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        inc        = 1'b0;
        jump       = 1'b0;
        we_jump    = 1'b0;
        data_jump  = '0;
        cmd_load   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) state_next = ST_FETCH;
            end
            ST_FETCH: state_next = ST_EXEC;
            ST_EXEC: begin
                state_next = ST_FETCH;
                case (op)
                    OP_NOP: inc = 1'b1;
                    OP_CMD: begin
                        cmd_load   = 1'b1;
                        state_next = ST_WAIT_CMD;
                    end
                    OP_LDJ: begin
                        inc        = 1'b1;
                        state_next = ST_OPND_WAIT;
                    end
                    OP_JMP: jump = 1'b1;
                    OP_LDC: begin
                        count_next = imm;
                        inc        = 1'b1;
                    end
                    OP_DJNZ: begin
                        if (count_reg >= CNT_W'(2)) begin
                            count_next = count_reg - CNT_W'(1);
                            jump       = 1'b1;
                        end else begin
                            count_next = '0;
                            inc        = 1'b1;
                        end
                    end
                    OP_WAIT: begin
                        if (ev_pad[imm[1:0]]) inc = 1'b1;
                        else state_next = ST_WAIT_EV;
                    end
                    OP_HALT: state_next = ST_HALT;
                    default: state_next = ST_FETCH;
                endcase
            end
            ST_OPND_WAIT: state_next = ST_OPND;
            ST_OPND: begin
                we_jump    = 1'b1;
                data_jump  = instr[WIDTH_ADDR-1:0];
                inc        = 1'b1;
                state_next = ST_FETCH;
            end
            ST_WAIT_EV: begin
                if (ev_pad[wait_idx_reg]) begin
                    inc        = 1'b1;
                    state_next = ST_FETCH;
                end
            end
            ST_WAIT_CMD: begin
                if (cmd_ready) begin
                    inc        = 1'b1;
                    state_next = ST_FETCH;
                end
            end
            ST_HALT: begin
                if (start) begin
                    inc        = 1'b1;
                    state_next = ST_FETCH;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg     <= ST_IDLE;
            count_reg     <= '0;
            cmd_valid_reg <= 1'b0;
            cmd_data_reg  <= '0;
            wait_idx_reg  <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            if (cmd_load) begin
                cmd_valid_reg <= 1'b1;
                cmd_data_reg  <= imm;
            end else if (state_reg == ST_WAIT_CMD && cmd_ready) begin
                cmd_valid_reg <= 1'b0;
            end
            if (state_reg == ST_EXEC && op == OP_WAIT) wait_idx_reg <= imm[1:0];
        end
    end

    assign cmd_valid = cmd_valid_reg;
    assign cmd_data  = cmd_data_reg;
    assign busy      = (state_reg != ST_IDLE) && (state_reg != ST_HALT);
    assign halted    = (state_reg == ST_HALT);

endmodule
